seq_tp: RTL and testbench
=========================

SEQ_TP -- requirements
Module: seq_tp

Interface
REQ-001 SHALL have parameter WIDTH, default 32, which is the data word width in bits (legal range 2..64).
REQ-002 SHALL have localparam RAIL_NUM, fixed at 2, which is the number of rails per bit (dual-rail).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state is on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port en_i, input, 1 bit: run enable.
REQ-006 SHALL have port mode_i, input, 2 bits: sequence select (0 Fibonacci, 1 counter, 2 walking-one, 3 checkerboard).
REQ-007 SHALL have port ack_i, input, 1 bit: four-phase acknowledge from the consumer.
REQ-008 SHALL have port out, output, [WIDTH-1:0][RAIL_NUM-1:0]: dual-rail data. Per bit, rails 01 = logic 0, 10 = logic 1, 00 = spacer, 11 = illegal.
REQ-009 SHALL have port cnt_o, output, 16 bits: count of completed handshakes.

Function
REQ-010 SHALL implement an FSM with states IDLE, DATA and NULL; out and cnt_o SHALL be driven directly from registers.
REQ-011 In IDLE, out SHALL be all-spacer; go to DATA when en_i=1 and ack_i=0, else stay.
REQ-012 In DATA, out SHALL be the dual-rail codeword of the current word W; go to NULL on the first cycle ack_i=1.
REQ-013 In NULL, out SHALL be all-spacer; when ack_i=0, advance W, increment cnt_o, then go to DATA if en_i=1, else IDLE.
REQ-014 out SHALL change only the cycle after the transition condition is sampled: one cycle latency from ack_i edge to out.
REQ-015 out SHALL never transition directly between two codewords, and SHALL never carry 11 on any bit.
REQ-016 Mode 0: hold registers A/B, W=B. Seeds are A=1, B=0. Advance is {A,B} <= {A+B mod 2^WIDTH, A}; the carry is discarded. Emitted sequence is 0,1,1,2,3,5,...
REQ-017 Mode 1: W seeds 0; advance is W+1 mod 2^WIDTH.
REQ-018 Mode 2: W seeds 1; advance is rotate-left by 1 (MSB wraps to LSB).
REQ-019 Mode 3: W seeds 0x55..5 (LSB=1); advance is bitwise complement.
REQ-020 mode_i SHALL be sampled only in IDLE. A value differing from the latched mode SHALL latch and reseed the generator. Changes outside IDLE SHALL be ignored until the next IDLE.
REQ-021 Dropping en_i in DATA or NULL SHALL NOT abort the handshake. The handshake completes, then the FSM enters IDLE. Re-enabling resumes at the next word, with no reseed.
REQ-022 If ack_i=1 while in IDLE, the FSM SHALL stay in IDLE until ack_i=0.
REQ-023 cnt_o SHALL wrap 65535 -> 0.

Reset
REQ-024 While rst=0: out SHALL be all-spacer immediately (asynchronously), FSM=IDLE, cnt_o=0, latched mode=0, generator at mode-0 seeds.
REQ-025 Reset asserted mid-handshake SHALL abandon it. After release the sequence restarts from the seed of the latched mode (mode 0) and then follows REQ-020.
REQ-026 Deassertion SHALL take effect at the first clk rising edge after rst=1.

Configuration
REQ-027 Macro SEQ_TP_ACK_SYNC_EN.
- Defined: ack_i SHALL pass through a two-flop synchronizer before the FSM, adding 2 cycles to REQ-014 latency (3 total).
- Undefined: ack_i SHALL feed the FSM directly.
- Function is otherwise identical.

Verification (WIDTH=8; consumer raises ack 3 cycles after a codeword and drops it 3 cycles after the spacer)
REQ-028 Mode 0, en_i=1 -> decoded words 0,1,1,2,3,5,8,13,21,34,55,89,144,233,121(=377 mod 256); cnt_o=15 after the 15th NULL->DATA.
REQ-029 Mode 1, 257 handshakes -> words 0..255 then 0; cnt_o=257. Separately, preload 65534 handshakes then 2 more -> cnt_o wraps to 0.
REQ-030 Hold ack_i=0 for 50 cycles in DATA -> out stable, no spacer, cnt_o unchanged. A checker asserts no 11 rail pair and no codeword-to-codeword transition throughout.
REQ-031 Drop en_i in DATA on word 5 -> handshake completes, IDLE spacer persists. Re-enable -> next word is 8.
REQ-032 Reset during DATA -> out all-spacer in the same cycle, cnt_o=0. After release -> first word 0.
REQ-033 In IDLE, switch mode_i to 2 -> 0x01,0x02,...,0x80,0x01. Switch to 3 mid-run -> ignored until IDLE, then 0x55,0xAA,0x55. Run each with and without SEQ_TP_ACK_SYNC_EN, checking 3-cycle vs 1-cycle ack-to-out latency.

Source files
------------

// File: rtl/seq_tp.sv
// ---------------------------------------------------------------------------
// seq_tp : dual-rail four-phase sequence generator
//
// Emits a word sequence as dual-rail codewords, returning to all-spacer
// between words, paced by a four-phase handshake with the consumer.
//
// Parameters
//   WIDTH     data word width in bits (2..64)
//   RAIL_NUM  rails per bit (fixed at 2)
//
// Ports
//   clk     system clock, rising edge
//   rst     asynchronous active-low reset
//   en_i    run enable
//   mode_i  sequence select: 0 Fibonacci, 1 counter, 2 walking-one,
//           3 checkerboard (sampled only in IDLE)
//   ack_i   four-phase acknowledge from the consumer
//   out     dual-rail data; per bit 01 = 0, 10 = 1, 00 = spacer
//   cnt_o   completed-handshake count (wraps at 16 bits)
//
// Build option
//   SEQ_TP_ACK_SYNC_EN  defined: ack_i passes through a two-flop
//                       synchronizer before the FSM (two extra cycles
//                       of ack-to-out latency).
//
// state | meaning
// IDLE  | all-spacer; waits for en_i=1 with ack_i=0; mode_i latched here
// DATA  | codeword of the current word; waits for ack_i=1
// NULL  | all-spacer; on ack_i=0 advances the word and counts
// ---------------------------------------------------------------------------
module seq_tp #(
   parameter  int WIDTH    = 32,
   localparam int RAIL_NUM = 2
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               en_i,
   input  logic [1:0]                         mode_i,
   input  logic                               ack_i,
   output logic [WIDTH-1:0][RAIL_NUM-1:0]     out,
   output logic [15:0]                        cnt_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1,
      NULL = 2'd2
   } state_t;

   state_t                            state_q;
   logic [WIDTH-1:0][RAIL_NUM-1:0]    out_q;
   logic [15:0]                       cnt_q;
   logic [1:0]                        mode_q;
   // w_q is the emitted word; in Fibonacci mode it is register B and a_q is A.
   logic [WIDTH-1:0]                  w_q;
   logic [WIDTH-1:0]                  a_q;

   logic                              ack_s;
   logic [WIDTH-1:0]                  seed_w;
   logic [WIDTH-1:0]                  adv_w;
   logic [WIDTH-1:0]                  adv_a;
   logic [WIDTH-1:0]                  idle_w;

`ifdef SEQ_TP_ACK_SYNC_EN
   logic [1:0] ack_sync_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ack_sync_q <= 2'b00;
      end else begin
         ack_sync_q <= {ack_sync_q[0], ack_i};
      end
   end

   assign ack_s = ack_sync_q[1];
`else
   assign ack_s = ack_i;
`endif

   function automatic logic [WIDTH-1:0][RAIL_NUM-1:0] encode(input logic [WIDTH-1:0] w);
      logic [WIDTH-1:0][RAIL_NUM-1:0] r;
      for (int i = 0; i < WIDTH; i++) begin
         r[i] = w[i] ? 2'b10 : 2'b01;
      end
      return r;
   endfunction

   function automatic logic [WIDTH-1:0] checker_seed();
      logic [WIDTH-1:0] s;
      for (int i = 0; i < WIDTH; i++) begin
         s[i] = ((i % 2) == 0);
      end
      return s;
   endfunction

   always_comb begin
      seed_w = '0;
      case (mode_i)
         2'd0:    seed_w = '0;
         2'd1:    seed_w = '0;
         2'd2:    seed_w = WIDTH'(1);
         default: seed_w = checker_seed();
      endcase
   end

   always_comb begin
      adv_w = w_q;
      adv_a = a_q;
      case (mode_q)
         2'd0: begin
            adv_w = a_q;
            adv_a = a_q + w_q;
         end
         2'd1:    adv_w = w_q + WIDTH'(1);
         2'd2:    adv_w = {w_q[WIDTH-2:0], w_q[WIDTH-1]};
         default: adv_w = ~w_q;
      endcase
   end

   // A mode change seen in IDLE reseeds in the same cycle, so a DATA entry
   // on that edge must already present the new seed.
   assign idle_w = (mode_i != mode_q) ? seed_w : w_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         out_q   <= '0;
         cnt_q   <= 16'd0;
         mode_q  <= 2'd0;
         a_q     <= WIDTH'(1);
         w_q     <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (mode_i != mode_q) begin
                  mode_q <= mode_i;
                  w_q    <= seed_w;
                  a_q    <= WIDTH'(1);
               end
               if (en_i && !ack_s) begin
                  state_q <= DATA;
                  out_q   <= encode(idle_w);
               end
            end
            DATA: begin
               if (ack_s) begin
                  state_q <= NULL;
                  out_q   <= '0;
               end
            end
            NULL: begin
               if (!ack_s) begin
                  w_q   <= adv_w;
                  a_q   <= adv_a;
                  cnt_q <= cnt_q + 16'd1;
                  if (en_i) begin
                     state_q <= DATA;
                     out_q   <= encode(adv_w);
                  end else begin
                     state_q <= IDLE;
                  end
               end
            end
            default: begin
               state_q <= IDLE;
               out_q   <= '0;
            end
         endcase
      end
   end

   assign out   = out_q;
   assign cnt_o = cnt_q;

endmodule

// File: tb/tb_seq_tp.sv
module tb_seq_tp;

   localparam int W = 8;
`ifdef SEQ_TP_ACK_SYNC_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 1;
`endif

   logic                 clk    = 1'b0;
   logic                 rst    = 1'b1;
   logic                 en_i   = 1'b0;
   logic [1:0]           mode_i = 2'd0;
   logic                 ack_i  = 1'b0;
   logic [W-1:0][1:0]    out;
   logic [15:0]          cnt_o;

   seq_tp #(.WIDTH(W)) dut (
      .clk    (clk),
      .rst    (rst),
      .en_i   (en_i),
      .mode_i (mode_i),
      .ack_i  (ack_i),
      .out    (out),
      .cnt_o  (cnt_o)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int viol  = 0;

   int m_mode = 0;
   int m_idx  = 0;
   int m_cnt  = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   // 0 = all spacer, 1 = valid codeword, 2 = illegal or mixed
   function automatic int cls(input logic [W-1:0][1:0] o);
      int nsp = 0;
      int nv  = 0;
      for (int i = 0; i < W; i++) begin
         if (o[i] == 2'b00) nsp++;
         else if (o[i] == 2'b01 || o[i] == 2'b10) nv++;
      end
      if (nsp == W) return 0;
      if (nv == W) return 1;
      return 2;
   endfunction

   function automatic logic [W-1:0] dec(input logic [W-1:0][1:0] o);
      logic [W-1:0] d;
      for (int i = 0; i < W; i++) d[i] = o[i][1];
      return d;
   endfunction

   // idx-th word of each sequence, straight from its definition
   function automatic logic [W-1:0] ref_word(input int m, input int idx);
      int a;
      int b;
      int t;
      case (m)
         0: begin
            a = 0;
            b = 1;
            for (int k = 0; k < idx; k++) begin
               t = (a + b) % 256;
               a = b;
               b = t;
            end
            return W'(a);
         end
         1:       return W'(idx % 256);
         2:       return W'(1 << (idx % 8));
         default: return (idx % 2 == 0) ? 8'h55 : 8'hAA;
      endcase
   endfunction

   logic [W-1:0][1:0] prev_out = '0;

   always @(negedge clk) begin
      if (cls(out) == 2) viol <= viol + 1;
      else if (cls(out) == 1 && cls(prev_out) == 1 && out != prev_out) viol <= viol + 1;
      prev_out <= out;
   end

   // One full handshake with a consumer that answers 3 cycles after each phase.
   task automatic hs(input bit fall_chk);
      int n;
      n = 0;
      while (cls(out) != 1 && n < 40) begin
         @(posedge clk); #1; n++;
      end
      chk("code_seen", 64'(cls(out)), 64'd1);
      chk($sformatf("word_m%0d_i%0d", m_mode, m_idx), 64'(dec(out)), 64'(ref_word(m_mode, m_idx)));
      repeat (3) @(posedge clk);
      #1 ack_i = 1'b1;
      n = 0;
      while (cls(out) != 0 && n < 20) begin
         @(posedge clk); #1; n++;
      end
      chk("ack_rise_lat", 64'(n), 64'(LAT));
      repeat (3) @(posedge clk);
      #1 ack_i = 1'b0;
      m_idx++;
      m_cnt = (m_cnt + 1) % 65536;
      if (fall_chk) begin
         n = 0;
         while (cls(out) != 1 && n < 20) begin
            @(posedge clk); #1; n++;
         end
         chk("ack_fall_lat", 64'(n), 64'(LAT));
         chk("cnt", 64'(cnt_o), 64'(m_cnt));
      end
   endtask

   logic [W-1:0][1:0] hold_w;
   int                nchg;

   initial begin
      #2 rst = 1'b0;
      #1;
      chk("rst_out", 64'(cls(out)), 64'd0);
      chk("rst_cnt", 64'(cnt_o), 64'd0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;

      // ack high in IDLE must keep the FSM idle even with en_i set
      ack_i = 1'b1;
      en_i  = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      chk("idle_ack_hold", 64'(cls(out)), 64'd0);
      ack_i = 1'b0;

      for (int k = 0; k < 15; k++) hs(1'b1);
      chk("cnt15", 64'(cnt_o), 64'd15);

      hold_w = out;
      nchg = 0;
      repeat (50) begin
         @(posedge clk); #1;
         if (out !== hold_w) nchg++;
      end
      chk("hold_stable", 64'(nchg), 64'd0);
      chk("hold_is_code", 64'(cls(out)), 64'd1);
      chk("hold_cnt", 64'(cnt_o), 64'd15);

      // asynchronous reset in DATA
      rst = 1'b0;
      #1;
      chk("rst_mid_out", 64'(cls(out)), 64'd0);
      chk("rst_mid_cnt", 64'(cnt_o), 64'd0);
      @(posedge clk);
      #1 rst = 1'b1;
      m_mode = 0; m_idx = 0; m_cnt = 0;

      for (int k = 0; k < 5; k++) hs(1'b1);
      en_i = 1'b0;
      hs(1'b0);
      repeat (10) @(posedge clk);
      #1;
      chk("en_drop_idle", 64'(cls(out)), 64'd0);
      chk("en_drop_cnt", 64'(cnt_o), 64'(m_cnt));
      en_i = 1'b1;
      hs(1'b1);

      // counter mode
      en_i = 1'b0;
      hs(1'b0);
      mode_i = 2'd1;
      repeat (3) @(posedge clk);
      #1;
      m_mode = 1; m_idx = 0; m_cnt = 0;
      rst = 1'b0;
      #1 rst = 1'b1;
      en_i = 1'b1;
      for (int k = 0; k < 257; k++) hs(1'b1);
      chk("cnt257", 64'(cnt_o), 64'd257);

      // counter wrap from a preloaded value
      en_i = 1'b0;
      hs(1'b0);
      repeat (5) @(posedge clk);
      #1;
      force dut.cnt_q = 16'd65534;
      #1;
      release dut.cnt_q;
      m_cnt = 65534;
      en_i = 1'b1;
      hs(1'b1);
      hs(1'b1);
      chk("cnt_wrap", 64'(cnt_o), 64'd0);

      // walking one, then mode change mid-run ignored until IDLE
      en_i = 1'b0;
      hs(1'b0);
      mode_i = 2'd2;
      repeat (3) @(posedge clk);
      #1;
      m_mode = 2; m_idx = 0;
      en_i = 1'b1;
      for (int k = 0; k < 9; k++) hs(1'b1);
      mode_i = 2'd3;
      for (int k = 0; k < 3; k++) hs(1'b1);
      en_i = 1'b0;
      hs(1'b0);
      repeat (5) @(posedge clk);
      #1;
      m_mode = 3; m_idx = 0;
      en_i = 1'b1;
      for (int k = 0; k < 3; k++) hs(1'b1);
      en_i = 1'b0;
      hs(1'b0);
      repeat (10) @(posedge clk);
      #1;

      chk("rail_violations", 64'(viol), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

endmodule
